// File: rtl/lsu_memprep.sv
// lsu_memprep -- MEMPREP-stage memory access sequencer.
//
// Turns one load/store op from the MEMPREP slot into a single memory request,
// holds the pipeline while the request and (for loads) the response are in
// flight, then returns an aligned, extended load result.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   invalid_MEMPREP            slot holds a bubble; no memory action
//   lsu_re_MEMPREP/_we_        op is a load / store
//   lsu_sign_extend_MEMPREP    load result sign-extended when 1
//   data_width_MEMPREP         00 byte, 01 half, 10/11 word
//   alu_result_MEMPREP         byte address
//   rs2_data_MEMPREP           store data (low bits significant)
//   mem_req_*/mem_addr/mem_we/mem_wstrb/mem_wdata   request channel
//   mem_rsp_valid/mem_rsp_data response channel (single-cycle valid)
//   load_data, load_valid      load result and its one-cycle pulse
//   misaligned                 one-cycle pulse for a rejected access
//   stall                      hold EX/MEMPREP and earlier stages
module lsu_memprep (
  input  logic        clk,
  input  logic        rst,
  input  logic        invalid_MEMPREP,
  input  logic        lsu_re_MEMPREP,
  input  logic        lsu_we_MEMPREP,
  input  logic        lsu_sign_extend_MEMPREP,
  input  logic [1:0]  data_width_MEMPREP,
  input  logic [31:0] alu_result_MEMPREP,
  input  logic [31:0] rs2_data_MEMPREP,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        w_mem_op;
  logic        w_aligned;
  logic        w_start;
  logic        w_misalign;
  logic        w_rsp_take;

  logic [29:0] r_addr_hi;
  logic [1:0]  r_off;
  logic [1:0]  r_width;
  logic        r_sext;
  logic        r_we;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;
  logic        r_load_valid;
  logic        r_misaligned;

  // Half needs an even address, word (and the 11 encoding) a 4-byte one.
  function automatic logic addr_aligned(input logic [1:0] width, input logic [1:0] off);
    case (width)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [1:0] width, input logic [1:0] off);
    case (width)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the data across lanes lets the strobe alone select the target bytes.
  function automatic logic [31:0] lane_wdata(input logic [1:0] width, input logic [31:0] data);
    case (width)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [1:0] width, input logic [1:0] off,
                                             input logic sext, input logic [31:0] raw);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (width)
      2'b00:   return {{24{sext & sh[7]}}, sh[7:0]};
      2'b01:   return {{16{sext & sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Decode of the op currently offered in the MEMPREP slot.
  always_comb begin
    w_mem_op   = lsu_re_MEMPREP | lsu_we_MEMPREP;
    w_aligned  = addr_aligned(data_width_MEMPREP, alu_result_MEMPREP[1:0]);
    w_start    = (r_state == S_IDLE) && !invalid_MEMPREP && w_mem_op && w_aligned;
    w_misalign = (r_state == S_IDLE) && !invalid_MEMPREP && w_mem_op && !w_aligned;
    w_rsp_take = (r_state == S_WAIT) && mem_rsp_valid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and stall decode.
  always_comb begin
    w_next = r_state;
    stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_start;
        if (w_start) begin
          w_next = S_REQ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (mem_req_ready) begin
          w_next = r_we ? S_DONE : S_WAIT;
        end else begin
          w_next = S_REQ;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_rsp_valid) begin
          w_next = S_DONE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request capture, load result and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_hi    <= 30'd0;
      r_off        <= 2'd0;
      r_width      <= 2'd0;
      r_sext       <= 1'b0;
      r_we         <= 1'b0;
      r_wstrb      <= 4'd0;
      r_wdata      <= 32'd0;
      r_load_data  <= 32'd0;
      r_load_valid <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= w_misalign;
      // WAIT is only entered by loads, so this pulse never fires for stores.
      r_load_valid <= w_rsp_take;
      if (w_start) begin
        r_addr_hi <= alu_result_MEMPREP[31:2];
        r_off     <= alu_result_MEMPREP[1:0];
        r_width   <= data_width_MEMPREP;
        r_sext    <= lsu_sign_extend_MEMPREP;
        r_we      <= lsu_we_MEMPREP;
        r_wstrb   <= lsu_we_MEMPREP ? lane_strobe(data_width_MEMPREP, alu_result_MEMPREP[1:0]) : 4'd0;
        r_wdata   <= lsu_we_MEMPREP ? lane_wdata(data_width_MEMPREP, rs2_data_MEMPREP) : 32'd0;
      end
      if (w_rsp_take) begin
        r_load_data <= load_align(r_width, r_off, r_sext, mem_rsp_data);
      end
    end
  end

  assign mem_req_valid = (r_state == S_REQ);
  assign mem_addr      = {r_addr_hi, 2'b00};
  assign mem_we        = r_we;
  assign mem_wstrb     = r_wstrb;
  assign mem_wdata     = r_wdata;
  assign load_data     = r_load_data;
  assign load_valid    = r_load_valid;
  assign misaligned    = r_misaligned;

endmodule

// File: tb/tb_lsu_memprep.sv
module tb_lsu_memprep;

  logic        clk = 1'b0;
  logic        rst;
  logic        invalid_MEMPREP;
  logic        lsu_re_MEMPREP;
  logic        lsu_we_MEMPREP;
  logic        lsu_sign_extend_MEMPREP;
  logic [1:0]  data_width_MEMPREP;
  logic [31:0] alu_result_MEMPREP;
  logic [31:0] rs2_data_MEMPREP;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        stall;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lsu_memprep dut (
    .clk                     (clk),
    .rst                     (rst),
    .invalid_MEMPREP         (invalid_MEMPREP),
    .lsu_re_MEMPREP          (lsu_re_MEMPREP),
    .lsu_we_MEMPREP          (lsu_we_MEMPREP),
    .lsu_sign_extend_MEMPREP (lsu_sign_extend_MEMPREP),
    .data_width_MEMPREP      (data_width_MEMPREP),
    .alu_result_MEMPREP      (alu_result_MEMPREP),
    .rs2_data_MEMPREP        (rs2_data_MEMPREP),
    .mem_req_valid           (mem_req_valid),
    .mem_req_ready           (mem_req_ready),
    .mem_addr                (mem_addr),
    .mem_we                  (mem_we),
    .mem_wstrb               (mem_wstrb),
    .mem_wdata               (mem_wdata),
    .mem_rsp_valid           (mem_rsp_valid),
    .mem_rsp_data            (mem_rsp_data),
    .load_data               (load_data),
    .load_valid              (load_valid),
    .misaligned              (misaligned),
    .stall                   (stall)
  );

  typedef struct {
    logic        inv;
    logic        re;
    logic        we;
    logic        sext;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rsp;
    logic        exp_mis;
    logic        exp_start;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    invalid_MEMPREP         = 1'b0;
    lsu_re_MEMPREP          = 1'b0;
    lsu_we_MEMPREP          = 1'b0;
    lsu_sign_extend_MEMPREP = 1'b0;
    data_width_MEMPREP      = 2'b00;
    alu_result_MEMPREP      = 32'd0;
    rs2_data_MEMPREP        = 32'd0;
  endtask

  // Advance one cycle, landing on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd0);
    chk({tag, ".stall"},     {31'd0, stall},         32'd0);
    chk({tag, ".load_valid"},{31'd0, load_valid},    32'd0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    invalid_MEMPREP         = v.inv;
    lsu_re_MEMPREP          = v.re;
    lsu_we_MEMPREP          = v.we;
    lsu_sign_extend_MEMPREP = v.sext;
    data_width_MEMPREP      = v.width;
    alu_result_MEMPREP      = v.addr;
    rs2_data_MEMPREP        = v.rs2;
    mem_req_ready           = 1'b1;
    #1;
    chk({tag, ".stall_start"}, {31'd0, stall}, {31'd0, v.exp_start});
    tick();
    idle_inputs();
    if (v.exp_start) begin
      chk({tag, ".req_valid"}, {31'd0, mem_req_valid}, 32'd1);
      chk({tag, ".addr"},      mem_addr,               v.exp_addr);
      chk({tag, ".we"},        {31'd0, mem_we},        {31'd0, v.we});
      chk({tag, ".wstrb"},     {28'd0, mem_wstrb},     {28'd0, v.exp_strb});
      if (v.we) begin
        chk({tag, ".wdata"}, mem_wdata, v.exp_wdata);
      end else begin
        chk({tag, ".wdata_rd"}, 32'd0, 32'd0 & mem_wdata);
      end
      chk({tag, ".stall_req"}, {31'd0, stall}, 32'd1);
      tick();
      if (v.we) begin
        check_quiet({tag, ".done"});
        tick();
      end else begin
        chk({tag, ".req_drop"},   {31'd0, mem_req_valid}, 32'd0);
        chk({tag, ".stall_wait"}, {31'd0, stall},         32'd1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = v.rsp;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'd0;
        chk({tag, ".load_valid"}, {31'd0, load_valid}, 32'd1);
        chk({tag, ".load_data"},  load_data,           v.exp_ld);
        chk({tag, ".stall_done"}, {31'd0, stall},      32'd0);
        tick();
        chk({tag, ".lv_pulse"},   {31'd0, load_valid}, 32'd0);
      end
    end else begin
      chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, v.exp_mis});
      check_quiet(tag);
      tick();
      chk({tag, ".mis_pulse"}, {31'd0, misaligned}, 32'd0);
      check_quiet({tag, ".after"});
    end
  endtask

  initial begin
    // inv re we sext width addr rs2 rsp | mis start addr strb wdata ld
    vt[0]  = '{1'b0,1'b0,1'b1,1'b0,2'b00,32'h0000_0103,32'hAABB_CCDD,32'h0,        1'b0,1'b1,32'h0000_0100,4'b1000,32'hDDDD_DDDD,32'h0};
    vt[1]  = '{1'b0,1'b0,1'b1,1'b0,2'b01,32'h0000_0202,32'h1122_3344,32'h0,        1'b0,1'b1,32'h0000_0200,4'b1100,32'h3344_3344,32'h0};
    vt[2]  = '{1'b0,1'b0,1'b1,1'b0,2'b10,32'h0000_0040,32'hCAFE_BABE,32'h0,        1'b0,1'b1,32'h0000_0040,4'b1111,32'hCAFE_BABE,32'h0};
    vt[3]  = '{1'b0,1'b1,1'b0,1'b1,2'b01,32'h0000_0202,32'h0,        32'h8001_1234,1'b0,1'b1,32'h0000_0200,4'b0000,32'h0,32'hFFFF_8001};
    vt[4]  = '{1'b0,1'b1,1'b0,1'b1,2'b00,32'h0000_0003,32'h0,        32'h80FF_0000,1'b0,1'b1,32'h0000_0000,4'b0000,32'h0,32'hFFFF_FF80};
    vt[5]  = '{1'b0,1'b1,1'b0,1'b0,2'b00,32'h0000_0002,32'h0,        32'h1234_5678,1'b0,1'b1,32'h0000_0000,4'b0000,32'h0,32'h0000_0034};
    vt[6]  = '{1'b0,1'b1,1'b0,1'b1,2'b11,32'h0000_0010,32'h0,        32'hDEAD_BEEF,1'b0,1'b1,32'h0000_0010,4'b0000,32'h0,32'hDEAD_BEEF};
    vt[7]  = '{1'b0,1'b1,1'b0,1'b0,2'b01,32'h0000_0000,32'h0,        32'h1234_F00D,1'b0,1'b1,32'h0000_0000,4'b0000,32'h0,32'h0000_F00D};
    vt[8]  = '{1'b0,1'b1,1'b0,1'b0,2'b10,32'h0000_0006,32'h0,        32'h0,        1'b1,1'b0,32'h0,4'b0000,32'h0,32'h0};
    vt[9]  = '{1'b0,1'b0,1'b1,1'b0,2'b01,32'h0000_0005,32'h1234_5678,32'h0,        1'b1,1'b0,32'h0,4'b0000,32'h0,32'h0};
    vt[10] = '{1'b1,1'b1,1'b0,1'b0,2'b10,32'h0000_0000,32'h0,        32'h0,        1'b0,1'b0,32'h0,4'b0000,32'h0,32'h0};
    vt[11] = '{1'b0,1'b0,1'b0,1'b0,2'b10,32'h0000_0000,32'h0,        32'h0,        1'b0,1'b0,32'h0,4'b0000,32'h0,32'h0};

    idle_inputs();
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
    rst           = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst.req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst.addr",      mem_addr,               32'd0);
    chk("rst.we",        {31'd0, mem_we},        32'd0);
    chk("rst.wstrb",     {28'd0, mem_wstrb},     32'd0);
    chk("rst.wdata",     mem_wdata,              32'd0);
    chk("rst.load_data", load_data,              32'd0);
    chk("rst.load_valid",{31'd0, load_valid},    32'd0);
    chk("rst.misaligned",{31'd0, misaligned},    32'd0);
    chk("rst.stall",     {31'd0, stall},         32'd0);

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vt[i]);
    end

    // Last load result survives misaligned, bubble and no-op slots.
    chk("hold.load_data", load_data, 32'h0000_F00D);

    // Backpressure: ready low for three cycles, request must stay put.
    lsu_re_MEMPREP     = 1'b1;
    data_width_MEMPREP = 2'b00;
    alu_result_MEMPREP = 32'h0000_0001;
    mem_req_ready      = 1'b0;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d.req_valid", i), {31'd0, mem_req_valid}, 32'd1);
      chk($sformatf("bp%0d.addr", i),      mem_addr,               32'd0);
      chk($sformatf("bp%0d.stall", i),     {31'd0, stall},         32'd1);
      tick();
    end
    chk("bp.req_valid_last", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    tick();
    chk("bp.req_drop", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0000_F700;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
    chk("bp.load_valid", {31'd0, load_valid}, 32'd1);
    chk("bp.load_data",  load_data,           32'h0000_00F7);
    tick();

    // Response outside WAIT is ignored.
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h5555_5555;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stray.load_valid", {31'd0, load_valid}, 32'd0);
    chk("stray.load_data",  load_data,           32'h0000_00F7);

    // Reset while waiting for read data abandons the load.
    lsu_re_MEMPREP     = 1'b1;
    data_width_MEMPREP = 2'b10;
    alu_result_MEMPREP = 32'h0000_0008;
    tick();
    idle_inputs();
    tick();
    chk("rw.stall_wait", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hFFFF_FFFF;
    tick();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rw%0d.load_valid", i), {31'd0, load_valid},    32'd0);
      chk($sformatf("rw%0d.load_data", i),  load_data,              32'd0);
      chk($sformatf("rw%0d.req_valid", i),  {31'd0, mem_req_valid}, 32'd0);
      chk($sformatf("rw%0d.addr", i),       mem_addr,               32'd0);
      chk($sformatf("rw%0d.stall", i),      {31'd0, stall},         32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_memprep.md
LSU_MEMPREP -- requirements
Module: lsu_memprep

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 invalid_MEMPREP  input  1  MEMPREP slot holds a bubble/squashed op; no memory action when 1.
REQ-004 lsu_re_MEMPREP  input  1  MEMPREP op is a load.
REQ-005 lsu_we_MEMPREP  input  1  MEMPREP op is a store; lsu_re and lsu_we never both 1.
REQ-006 lsu_sign_extend_MEMPREP  input  1  load result sign-extended (1) or zero-extended (0).
REQ-007 data_width_MEMPREP  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 alu_result_MEMPREP  input  32  byte address of the access.
REQ-009 rs2_data_MEMPREP  input  32  store data, low bits significant.
REQ-010 mem_req_valid  output  1  memory request valid.
REQ-011 mem_req_ready  input  1  memory accepts request when valid and ready are both 1 on a posedge.
REQ-012 mem_addr  output  32  word address, alu_result with bits [1:0] forced to 0.
REQ-013 mem_we  output  1  request is a write.
REQ-014 mem_wstrb  output  4  byte-lane write enables; 0000 for reads.
REQ-015 mem_wdata  output  32  lane-replicated store data.
REQ-016 mem_rsp_valid  input  1  read data valid, one cycle.
REQ-017 mem_rsp_data  input  32  raw read word.
REQ-018 load_data  output  32  aligned, extended load result.
REQ-019 load_valid  output  1  one-cycle pulse; load_data valid.
REQ-020 misaligned  output  1  one-cycle pulse; access rejected as misaligned.
REQ-021 stall  output  1  hold EX/MEMPREP and earlier stages while 1.

Function
REQ-022 Four-state FSM: IDLE, REQ, WAIT, DONE.
REQ-023 Start condition: state IDLE, invalid_MEMPREP=0, (lsu_re|lsu_we)=1, access aligned.
REQ-024 Aligned: byte always; half needs addr[0]=0; word needs addr[1:0]=00.
REQ-025 stall = (IDLE and start condition) | state REQ | state WAIT; combinational, 0 in DONE.
REQ-026 IDLE on start: capture address, width, sign-extend, we, wstrb, wdata; next state REQ.
REQ-027 REQ: mem_req_valid=1; mem_addr/mem_we/mem_wstrb/mem_wdata from captured values, stable until handshake.
REQ-028 REQ on handshake: store -> DONE; load -> WAIT; mem_req_valid drops the following cycle.
REQ-029 WAIT: on mem_rsp_valid=1, register aligned result into load_data; next state DONE.
REQ-030 DONE: load_valid=1 for loads only; next state IDLE unconditionally.
REQ-031 mem_rsp_valid outside WAIT is ignored.
REQ-032 Strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-033 wdata: byte {4{rs2[7:0]}}; half {2{rs2[15:0]}}; word rs2.
REQ-034 Load align: shift mem_rsp_data right by 8*addr[1:0]; keep 8/16/32 bits; extend per sign flag.
REQ-035 Misaligned with invalid_MEMPREP=0 in IDLE: misaligned=1 one cycle, no request, stall=0, state stays IDLE.
REQ-036 invalid_MEMPREP=1 or no memory op in IDLE: no request, no stall, no pulses.
REQ-037 load_data holds last value between loads; minimum load latency from start to load_valid is 3 cycles with ready=1 and a rsp one cycle after handshake.

Reset
REQ-038 rst=1: state IDLE; mem_req_valid, mem_we, mem_wstrb, mem_wdata, mem_addr, load_data, load_valid, misaligned, stall all 0 next cycle.
REQ-039 Reset mid-REQ or mid-WAIT abandons the op; a later mem_rsp_valid is ignored.

Verification
REQ-040 Store byte, addr 0x103, rs2 0xAABBCCDD, ready=1 -> one request, addr 0x100, wstrb 1000, wdata 0xDDDDDDDD, stall 2 cycles, no load_valid.
REQ-041 Load half signed, addr 0x202, rsp 0x8001_1234 -> load_data 0xFFFF8001, load_valid one pulse.
REQ-042 Load byte unsigned, addr 0x1, rsp 0x0000_F700, ready held 0 for 3 cycles -> req_valid and addr stable, then load_data 0x000000F7.
REQ-043 Load word addr 0x6 -> misaligned pulse, no mem_req_valid, stall 0; invalid_MEMPREP=1 load -> no activity.
REQ-044 rst asserted in WAIT, rsp arrives after -> IDLE, load_valid never asserted, all outputs 0.
